// File: rtl/aes_inv_data_path.sv
// Byte-serial AES-128 inverse cipher: 16 ciphertext bytes in, 16 plaintext bytes out.
// Latency: start cycle = 0, plaintext byte k appears registered on d_out at cycle 197+k.
// Backpressure: none; one block at a time, start is ignored while busy is high.
module aes_inv_data_path #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] d_in,
  input  logic [7:0] rk_in,
  output logic [3:0] rk_round,
  output logic [3:0] rk_idx,
  output logic [7:0] d_out,
  output logic       d_out_valid,
  output logic       busy
);

  localparam logic [3:0] LAST_RK     = 4'(NR);
  localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUBK,
    S_IMC,
    S_OUT
  } fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] round_q, round_d;
  logic [7:0] state_q [16];
  logic [7:0] state_d [16];
  logic [7:0] nxt_q [16];
  logic [7:0] nxt_d [16];
  logic [7:0] d_out_q, d_out_d;
  logic       d_out_valid_q, d_out_valid_d;
  logic       busy_q, busy_d;

  logic [7:0]  sb_in, sb_out;
  logic [3:0]  col_base;
  logic [31:0] col_in, col_out;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse for a != 0 and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Undo the forward affine map (including its 0x63 constant).
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // The affine map is outermost in the forward S-box, so it is peeled first here.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction

  // Source byte index for output byte k of InvShiftRows.
  function automatic logic [3:0] invsr(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2] - r;
    return {c, r};
  endfunction

  // One column of InvMixColumns; byte 0 of the column sits in [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Shared datapath: one InvSbox (SUBK and OUT read the same shifted byte) and one column mixer.
  always_comb begin
    sb_in    = state_q[invsr(cnt_q)];
    sb_out   = inv_sbox(sb_in);
    col_base = {cnt_q[1:0], 2'b00};
    col_in   = {state_q[col_base], state_q[col_base + 4'd1],
                state_q[col_base + 4'd2], state_q[col_base + 4'd3]};
    col_out  = inv_mix_col(col_in);
  end

  // Sequencer and next-state computation for every register.
  always_comb begin
    fsm_d         = fsm_q;
    cnt_d         = cnt_q;
    round_d       = round_q;
    state_d       = state_q;
    nxt_d         = nxt_q;
    d_out_d       = d_out_q;
    d_out_valid_d = 1'b0;
    busy_d        = busy_q;
    rk_round      = LAST_RK;
    rk_idx        = 4'd0;

    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d[0] = d_in ^ rk_in;
          cnt_d      = 4'd1;
          fsm_d      = S_LOAD;
          busy_d     = 1'b1;
        end
      end

      S_LOAD: begin
        rk_idx         = cnt_q;
        state_d[cnt_q] = d_in ^ rk_in;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          fsm_d   = S_SUBK;
          round_d = FIRST_ROUND;
          cnt_d   = 4'd0;
        end
      end

      S_SUBK: begin
        rk_round     = round_q;
        rk_idx       = cnt_q;
        nxt_d[cnt_q] = sb_out ^ rk_in;
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // nxt_d already carries byte 15 written above.
          state_d = nxt_d;
          fsm_d   = S_IMC;
          cnt_d   = 4'd0;
        end
      end

      S_IMC: begin
        // Key is not consumed here; keep the address where SUBK left it.
        rk_round                  = round_q;
        rk_idx                    = 4'd15;
        state_d[col_base]         = col_out[31:24];
        state_d[col_base + 4'd1]  = col_out[23:16];
        state_d[col_base + 4'd2]  = col_out[15:8];
        state_d[col_base + 4'd3]  = col_out[7:0];
        cnt_d                     = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          cnt_d = 4'd0;
          if (round_q == 4'd1) begin
            fsm_d = S_OUT;
          end else begin
            round_d = round_q - 4'd1;
            fsm_d   = S_SUBK;
          end
        end
      end

      S_OUT: begin
        rk_round      = 4'd0;
        rk_idx        = cnt_q;
        d_out_d       = sb_out ^ rk_in;
        d_out_valid_d = 1'b1;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          fsm_d  = S_IDLE;
          busy_d = 1'b0;
          cnt_d  = 4'd0;
        end
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // All state, synchronously cleared by rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q         <= S_IDLE;
      cnt_q         <= 4'd0;
      round_q       <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        state_q[i] <= 8'h00;
        nxt_q[i]   <= 8'h00;
      end
      d_out_q       <= 8'h00;
      d_out_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      cnt_q         <= cnt_d;
      round_q       <= round_d;
      for (int i = 0; i < 16; i++) begin
        state_q[i] <= state_d[i];
        nxt_q[i]   <= nxt_d[i];
      end
      d_out_q       <= d_out_d;
      d_out_valid_q <= d_out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign d_out       = d_out_q;
  assign d_out_valid = d_out_valid_q;
  assign busy        = busy_q;

endmodule
